dmac_channel_ctrl: RTL and testbench
====================================

# dmac_channel_ctrl

Control FSM for one DMA channel; sits directly upstream of the channel datapath and drives every datapath select/enable strobe from the datapath status flags and the AHB master handshake. Per burst it sequences config load, bus request, a read burst into the channel FIFO, a write burst out of it, and transfer-size decrement, until the transfer is exhausted. It owns the AHB control signals (`hbusreq`, `htrans`, `hwrite`); address and write data come from the datapath.

## Interface
- No parameters.

- `clk` in 1: channel clock.
- `rst` in 1: reset, synchronous, active-high.
- `ch_en` in 1: start request; sampled in IDLE only.
- `hgrant` in 1: AHB bus grant.
- `hready` in 1: AHB data-phase complete.
- `bs0` `tslb` `ts0` `fifo_full` `fifo_empty` in 1 each: datapath status.
- `s_sel` `d_sel` `b_sel` `t_sel` out 1 each: datapath mux selects.
- `s_en` `d_en` `ts_en` `burst_en` `count_en` out 1 each: datapath register enables.
- `h_sel` out 1: 0 = source address on bus, 1 = destination address.
- `wr_en` `rd_en` out 1 each: FIFO push / pop.
- `trigger` out 1: gates FIFO head onto write data.
- `hbusreq` out 1: bus request.
- `htrans` out 2: AHB transfer type, IDLE=00, NONSEQ=10, SEQ=11.
- `hwrite` out 1: 1 during write phase.
- `ch_busy` out 1: high in every state except IDLE.
- `ch_done` out 1: one-cycle completion pulse.
- `ch_abort` in 1: only present with `DMAC_CH_ABORT_EN`.

## Operation
- States: IDLE, CONFIG, SIZE, RD_REQ, RD_ADDR, RD_DATA, RD_CHK, WR_REQ, WR_ADDR, WR_DATA, WR_CHK, DONE.
- All outputs default 0 (`htrans`=IDLE) unless listed below.
- IDLE: `ch_en`=1 -> CONFIG. `ch_en` is ignored in all other states.
- CONFIG: `s_en`=`s_sel`=`d_en`=`d_sel`=`ts_en`=`t_sel`=1. Next state is SIZE.
- SIZE: `ts0`=1 -> DONE. Otherwise `burst_en`=1 with `b_sel`=`tslb`, so a remainder smaller than the burst moves as single words; next state is RD_REQ.
- RD_REQ: `hbusreq`=1; `hgrant`=1 -> RD_ADDR.
- RD_ADDR: `hbusreq`=1, `h_sel`=0. `htrans`=NONSEQ on the first beat of the burst, SEQ otherwise. Next state is RD_DATA.
- RD_DATA: `hbusreq`=1. Hold while `hready`=0. On `hready`=1: `wr_en`=`count_en`=`s_en`=1 (`s_sel`=0, increment), then go to RD_CHK.
- RD_CHK: `bs0`=1 -> WR_REQ, otherwise RD_ADDR.
- WR_REQ, WR_ADDR, WR_DATA, WR_CHK mirror the read states with `h_sel`=1 and `hwrite`=1.
  - In WR_DATA, `trigger`=1 throughout.
  - On `hready`=1 in WR_DATA: `rd_en`=`count_en`=`d_en`=1 (`d_sel`=0).
- WR_CHK: `bs0`=1 -> `ts_en`=1 (`t_sel`=0, decrement), then SIZE. Otherwise WR_ADDR.
- DONE: `ch_done`=1 for one cycle, then IDLE.
- FIFO guards, both required for correctness:
  - `wr_en` is never asserted while `fifo_full`=1. If `fifo_full`=1 in RD_ADDR, hold in RD_ADDR with `htrans`=IDLE.
  - `rd_en` is never asserted while `fifo_empty`=1. If `fifo_empty`=1 in WR_ADDR, hold likewise.
- `hgrant` deassert mid-burst: finish the current data phase, then return to RD_REQ or WR_REQ before the next address phase; NONSEQ is reissued after regrant.

## Timing
- `rst` high at a clock edge -> IDLE next cycle. All outputs 0, including mid-burst; no bus cleanup is performed.
- Start to first read address phase: `ch_en` edge, CONFIG, SIZE, RD_REQ, then RD_ADDR. Minimum 4 cycles with `hgrant` already high.
- Each beat costs 3 cycles (ADDR, DATA, CHK) plus 1 cycle per `hready`=0 wait state. Address and data phases do not overlap.
- `ts0` is sampled in SIZE, one cycle after the `ts_en` decrement, so it reflects the updated size.
- Every output is registered-state-decoded (Moore), except strobes qualified by `hready` in RD_DATA/WR_DATA, which are combinational on `hready`.

## Configuration
- `DMAC_CH_ABORT_EN` defined: adds input `ch_abort`.
  - Abort in IDLE, CONFIG, SIZE or any REQ/CHK state -> DONE next cycle.
  - Abort in ADDR/DATA states: the current beat completes (waits on `hready`), then DONE.
  - `ch_done` pulses in both cases; FIFO contents are left as is.
- Not defined: no `ch_abort` port; the transfer always runs to `ts0`.

## Structure
- `dmac_pkg` holds:
  - the state enum type `dmac_ch_state_t`;
  - the HTRANS localparams `HTRANS_IDLE`, `HTRANS_NONSEQ`, `HTRANS_SEQ`.
- Single module, no sub-module: a state register plus a next-state/output decode, and a `first_beat` flop for NONSEQ/SEQ selection.

## Test plan
- Model the datapath flags with a behavioural datapath, `hgrant`=`hready`=1. T_Size=8, B_Size=4 -> read 4 / write 4 / read 4 / write 4; 16 `count_en`; `ts_en` decrement twice; `ch_done` once.
- T_Size=6, B_Size=4 -> burst of 4, then `b_sel`=1, then 2 single read/write pairs; NONSEQ on every single beat.
- T_Size=0 -> CONFIG, SIZE, DONE; `hbusreq` never asserted; `ch_done` 3 cycles after `ch_en`.
- `hready` low for 3 cycles in the 2nd read beat -> RD_DATA held 3 extra cycles; `wr_en` exactly once for that beat.
- `hgrant` dropped after beat 2 of 4 -> beat 2 completes, RD_REQ entered, NONSEQ on beat 3 after regrant.
- `rst` during WR_DATA -> all outputs 0 next cycle. With `DMAC_CH_ABORT_EN`: `ch_abort` in RD_DATA with `hready`=0 -> DONE only after `hready`=1.

Source files
------------

// File: rtl/dmac_pkg.sv
// Shared types for the DMA channel controller: FSM state encoding and AHB HTRANS codes.
package dmac_pkg;

   typedef enum logic [3:0] {
      CH_IDLE    = 4'd0,
      CH_CONFIG  = 4'd1,
      CH_SIZE    = 4'd2,
      CH_RD_REQ  = 4'd3,
      CH_RD_ADDR = 4'd4,
      CH_RD_DATA = 4'd5,
      CH_RD_CHK  = 4'd6,
      CH_WR_REQ  = 4'd7,
      CH_WR_ADDR = 4'd8,
      CH_WR_DATA = 4'd9,
      CH_WR_CHK  = 4'd10,
      CH_DONE    = 4'd11
   } dmac_ch_state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   function automatic logic [1:0] addr_htrans(input logic first_beat);
      return first_beat ? HTRANS_NONSEQ : HTRANS_SEQ;
   endfunction

endpackage

// File: rtl/dmac_channel_ctrl.sv
// Control FSM for one DMA channel: burst read into the channel FIFO, burst write out, size decrement.
// Optional abort input enabled by defining DMAC_CH_ABORT_EN.
module dmac_channel_ctrl
   import dmac_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ch_en,
   input  logic       hgrant,
   input  logic       hready,
   input  logic       bs0,
   input  logic       tslb,
   input  logic       ts0,
   input  logic       fifo_full,
   input  logic       fifo_empty,
`ifdef DMAC_CH_ABORT_EN
   input  logic       ch_abort,
`endif
   output logic       s_sel,
   output logic       d_sel,
   output logic       b_sel,
   output logic       t_sel,
   output logic       s_en,
   output logic       d_en,
   output logic       ts_en,
   output logic       burst_en,
   output logic       count_en,
   output logic       h_sel,
   output logic       wr_en,
   output logic       rd_en,
   output logic       trigger,
   output logic       hbusreq,
   output logic [1:0] htrans,
   output logic       hwrite,
   output logic       ch_busy,
   output logic       ch_done
);

   dmac_ch_state_t state_q, state_d;
   logic           first_beat_q, first_beat_d;
   logic           abort_s;
   logic           abort_pend_s;

`ifdef DMAC_CH_ABORT_EN
   logic abort_q, abort_d;

   // An abort seen during an address/data phase is remembered until the beat completes.
   always_comb begin
      abort_d = 1'b0;
      if ((state_q == CH_RD_ADDR) || (state_q == CH_RD_DATA) ||
          (state_q == CH_WR_ADDR) || (state_q == CH_WR_DATA)) begin
         abort_d = abort_q | ch_abort;
      end else begin
         abort_d = 1'b0;
      end
   end

   // Abort memory register.
   always_ff @(posedge clk) begin
      if (rst) begin
         abort_q <= 1'b0;
      end else begin
         abort_q <= abort_d;
      end
   end

   assign abort_s      = ch_abort;
   assign abort_pend_s = abort_q | ch_abort;
`else
   assign abort_s      = 1'b0;
   assign abort_pend_s = 1'b0;
`endif

   // Next-state and output decode; only the hready-qualified strobes depend on live inputs.
   always_comb begin
      state_d      = state_q;
      first_beat_d = first_beat_q;
      s_sel        = 1'b0;
      d_sel        = 1'b0;
      b_sel        = 1'b0;
      t_sel        = 1'b0;
      s_en         = 1'b0;
      d_en         = 1'b0;
      ts_en        = 1'b0;
      burst_en     = 1'b0;
      count_en     = 1'b0;
      h_sel        = 1'b0;
      wr_en        = 1'b0;
      rd_en        = 1'b0;
      trigger      = 1'b0;
      hbusreq      = 1'b0;
      htrans       = HTRANS_IDLE;
      hwrite       = 1'b0;
      ch_busy      = (state_q != CH_IDLE);
      ch_done      = 1'b0;

      case (state_q)
         CH_IDLE: begin
            if (abort_s) begin
               state_d = CH_DONE;
            end else if (ch_en) begin
               state_d = CH_CONFIG;
            end else begin
               state_d = CH_IDLE;
            end
         end
         CH_CONFIG: begin
            s_en  = 1'b1;
            s_sel = 1'b1;
            d_en  = 1'b1;
            d_sel = 1'b1;
            ts_en = 1'b1;
            t_sel = 1'b1;
            state_d = abort_s ? CH_DONE : CH_SIZE;
         end
         CH_SIZE: begin
            first_beat_d = 1'b1;
            if (abort_s || ts0) begin
               state_d = CH_DONE;
            end else begin
               // A remainder shorter than the burst is moved one word per burst.
               burst_en = 1'b1;
               b_sel    = tslb;
               state_d  = CH_RD_REQ;
            end
         end
         CH_RD_REQ: begin
            hbusreq      = 1'b1;
            first_beat_d = 1'b1;
            if (abort_s) begin
               state_d = CH_DONE;
            end else if (hgrant) begin
               state_d = CH_RD_ADDR;
            end else begin
               state_d = CH_RD_REQ;
            end
         end
         CH_RD_ADDR: begin
            hbusreq = 1'b1;
            if (fifo_full) begin
               state_d = abort_s ? CH_DONE : CH_RD_ADDR;
            end else begin
               htrans       = addr_htrans(first_beat_q);
               first_beat_d = 1'b0;
               state_d      = CH_RD_DATA;
            end
         end
         CH_RD_DATA: begin
            hbusreq = 1'b1;
            if (hready) begin
               wr_en    = 1'b1;
               count_en = 1'b1;
               s_en     = 1'b1;
               state_d  = abort_pend_s ? CH_DONE : CH_RD_CHK;
            end else begin
               state_d = CH_RD_DATA;
            end
         end
         CH_RD_CHK: begin
            if (abort_s) begin
               state_d = CH_DONE;
            end else if (bs0) begin
               state_d = CH_WR_REQ;
            end else if (hgrant) begin
               state_d = CH_RD_ADDR;
            end else begin
               state_d = CH_RD_REQ;
            end
         end
         CH_WR_REQ: begin
            hbusreq      = 1'b1;
            h_sel        = 1'b1;
            hwrite       = 1'b1;
            first_beat_d = 1'b1;
            if (abort_s) begin
               state_d = CH_DONE;
            end else if (hgrant) begin
               state_d = CH_WR_ADDR;
            end else begin
               state_d = CH_WR_REQ;
            end
         end
         CH_WR_ADDR: begin
            hbusreq = 1'b1;
            h_sel   = 1'b1;
            hwrite  = 1'b1;
            if (fifo_empty) begin
               state_d = abort_s ? CH_DONE : CH_WR_ADDR;
            end else begin
               htrans       = addr_htrans(first_beat_q);
               first_beat_d = 1'b0;
               state_d      = CH_WR_DATA;
            end
         end
         CH_WR_DATA: begin
            hbusreq = 1'b1;
            h_sel   = 1'b1;
            hwrite  = 1'b1;
            trigger = 1'b1;
            if (hready) begin
               rd_en    = 1'b1;
               count_en = 1'b1;
               d_en     = 1'b1;
               state_d  = abort_pend_s ? CH_DONE : CH_WR_CHK;
            end else begin
               state_d = CH_WR_DATA;
            end
         end
         CH_WR_CHK: begin
            if (abort_s) begin
               state_d = CH_DONE;
            end else if (bs0) begin
               ts_en   = 1'b1;
               state_d = CH_SIZE;
            end else if (hgrant) begin
               state_d = CH_WR_ADDR;
            end else begin
               state_d = CH_WR_REQ;
            end
         end
         CH_DONE: begin
            ch_done = 1'b1;
            state_d = CH_IDLE;
         end
         default: begin
            state_d = CH_IDLE;
         end
      endcase
   end

   // State and burst-position registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= CH_IDLE;
         first_beat_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         first_beat_q <= first_beat_d;
      end
   end

endmodule

// File: tb/tb_dmac_channel_ctrl.sv
// Self-checking bench for dmac_channel_ctrl: behavioural datapath/FIFO, randomized bus handshake,
// and a transfer-level model of the expected beat sequence.
module tb_dmac_channel_ctrl;
   import dmac_pkg::*;

   localparam int FIFO_DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ch_en = 1'b0;
   logic hgrant = 1'b1;
   logic hready = 1'b1;
   logic bs0, tslb, ts0, fifo_full, fifo_empty;
   logic s_sel, d_sel, b_sel, t_sel, s_en, d_en, ts_en, burst_en, count_en;
   logic h_sel, wr_en, rd_en, trigger, hbusreq, hwrite, ch_busy, ch_done;
   logic [1:0] htrans;
`ifdef DMAC_CH_ABORT_EN
   logic ch_abort = 1'b0;
`endif

   dmac_channel_ctrl dut (
      .clk(clk), .rst(rst), .ch_en(ch_en), .hgrant(hgrant), .hready(hready),
      .bs0(bs0), .tslb(tslb), .ts0(ts0), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
`ifdef DMAC_CH_ABORT_EN
      .ch_abort(ch_abort),
`endif
      .s_sel(s_sel), .d_sel(d_sel), .b_sel(b_sel), .t_sel(t_sel), .s_en(s_en), .d_en(d_en),
      .ts_en(ts_en), .burst_en(burst_en), .count_en(count_en), .h_sel(h_sel),
      .wr_en(wr_en), .rd_en(rd_en), .trigger(trigger), .hbusreq(hbusreq), .htrans(htrans),
      .hwrite(hwrite), .ch_busy(ch_busy), .ch_done(ch_done)
   );

   always #5 clk = ~clk;

   int err_cnt = 0;
   int chk_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] out_vec();
      return {s_sel, d_sel, b_sel, t_sel, s_en, d_en, ts_en, burst_en, count_en, h_sel,
              wr_en, rd_en, trigger, hbusreq, htrans, hwrite, ch_busy, ch_done};
   endfunction

   // Behavioural datapath: transfer size, burst length/position and FIFO occupancy.
   int cfg_t = 0, cfg_b = 4;
   int tsize = 0, blen = 1, bcnt = 0, fcnt = 0;
   bit stall_full = 1'b0, stall_empty = 1'b0;

   assign ts0        = (tsize == 0);
   assign tslb       = (tsize < cfg_b);
   assign bs0        = (bcnt == 0);
   assign fifo_full  = (fcnt >= FIFO_DEPTH) || stall_full;
   assign fifo_empty = (fcnt == 0) || stall_empty;

   always @(posedge clk) begin
      if (rst) begin
         tsize <= 0; blen <= 1; bcnt <= 0; fcnt <= 0;
      end else begin
         if (ts_en) tsize <= t_sel ? cfg_t : tsize - blen;
         if (burst_en) begin
            blen <= b_sel ? 1 : cfg_b;
            bcnt <= 0;
         end else if (count_en) begin
            bcnt <= (bcnt + 1 >= blen) ? 0 : bcnt + 1;
         end
         if (wr_en && !rd_en) fcnt <= fcnt + 1;
         else if (rd_en && !wr_en) fcnt <= fcnt - 1;
      end
   end

   // Bus/FIFO stimulus driver: random wait states and FIFO stalls, plus scheduled disturbances.
   int rdy_pct = 0, stall_pct = 0;
   int rdy_lo_req = 0, gnt_lo_req = 0, abort_req = 0;
   int rdy_lo_done = 0, gnt_lo_done = 0, abort_done = 0;
   bit in_data = 1'b0;

   always @(posedge clk) begin
      in_data = in_data ? !(wr_en || rd_en) : (htrans != HTRANS_IDLE);
      #1;
      if (rdy_lo_done < rdy_lo_req) begin
         hready = 1'b0;
         rdy_lo_done++;
      end else begin
         hready = ($urandom_range(0, 99) < rdy_pct) ? 1'b0 : 1'b1;
      end
      if (gnt_lo_done < gnt_lo_req) begin
         hgrant = 1'b0;
         gnt_lo_done++;
      end else begin
         hgrant = 1'b1;
      end
`ifdef DMAC_CH_ABORT_EN
      ch_abort = (abort_done < abort_req);
      if (ch_abort) abort_done++;
`endif
      if (in_data) begin
         stall_full = 1'b0; stall_empty = 1'b0;
      end else begin
         stall_full  = ($urandom_range(0, 99) < stall_pct);
         stall_empty = ($urandom_range(0, 99) < stall_pct);
      end
   end

   // Transfer monitor: records every completed beat and counts strobes and rule violations.
   bit mon_en = 1'b0, mon_en_d = 1'b0;
   int inject = 0;
   int cyc = 0, addr_cyc = 0, prev_done_cyc = 0, done_cyc = 0, first_addr_cyc = -1;
   int n_count, n_tsdec, n_done, n_busreq, n_viol, n_addr_rd, n_sen, n_den;
   logic [1:0] last_trans = HTRANS_IDLE;
   int q_dir[$], q_ns[$], q_dlen[$], q_gap[$];

   always @(negedge clk) begin
      cyc++;
      if (mon_en && !mon_en_d) begin
         q_dir.delete(); q_ns.delete(); q_dlen.delete(); q_gap.delete();
         n_count = 0; n_tsdec = 0; n_done = 0; n_busreq = 0; n_viol = 0; n_addr_rd = 0;
         n_sen = 0; n_den = 0; first_addr_cyc = -1; prev_done_cyc = cyc; addr_cyc = cyc;
      end
      if (mon_en) begin
         if (htrans != HTRANS_IDLE) begin
            if (first_addr_cyc < 0) first_addr_cyc = cyc;
            q_gap.push_back(cyc - prev_done_cyc);
            addr_cyc   = cyc;
            last_trans = htrans;
            if (!hwrite) begin
               n_addr_rd++;
               if (n_addr_rd == 2 && (inject == 1 || inject == 3)) rdy_lo_req += 3;
               if (n_addr_rd == 2 && inject == 2) gnt_lo_req += 2;
               if (n_addr_rd == 2 && inject == 3) abort_req++;
            end
            if (!hgrant || (hwrite !== h_sel)) n_viol++;
         end
         if (wr_en || rd_en) begin
            q_dir.push_back(int'(rd_en));
            q_ns.push_back(int'(last_trans == HTRANS_NONSEQ));
            q_dlen.push_back(cyc - addr_cyc);
            prev_done_cyc = cyc;
         end
         if ((wr_en && fifo_full) || (rd_en && fifo_empty) || (wr_en && rd_en)) n_viol++;
         if ((count_en !== (wr_en || rd_en)) || (rd_en && !trigger)) n_viol++;
         if (hbusreq && !ch_busy) n_viol++;
         if (count_en) n_count++;
         if (ts_en && !t_sel) n_tsdec++;
         if (s_en) n_sen++;
         if (d_en) n_den++;
         if (hbusreq) n_busreq++;
         if (ch_done) begin
            n_done++;
            done_cyc = cyc;
         end
      end
      mon_en_d = mon_en;
   end

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic run_xfer(input int t, input int b, input int rpct, input int spct, input int inj);
      int exp_dir[$];
      int exp_ns[$];
      int rem, bl, nbursts, seq_err, ns_err, dl_err, en_cyc, nb;
      cfg_t = t; cfg_b = b; rdy_pct = rpct; stall_pct = spct; inject = inj;
      @(posedge clk); #1;
      mon_en = 1'b1; ch_en = 1'b1;
      en_cyc = cyc + 1;
      @(posedge clk); #1 ch_en = 1'b0;
      for (int i = 0; i < 4000 && n_done == 0; i++) @(negedge clk);
      repeat (3) @(posedge clk);
      #1 mon_en = 1'b0; rdy_pct = 0; stall_pct = 0; inject = 0;
      @(negedge clk);

      rem = t; nbursts = 0;
      while (rem > 0) begin
         bl = (rem < b) ? 1 : b;
         for (int i = 0; i < bl; i++) begin exp_dir.push_back(0); exp_ns.push_back(int'(i == 0)); end
         for (int i = 0; i < bl; i++) begin exp_dir.push_back(1); exp_ns.push_back(int'(i == 0)); end
         rem -= bl; nbursts++;
      end
      if (inj == 2 && exp_ns.size() > 2) exp_ns[2] = 1;
      if (inj == 3) begin
         exp_dir = '{0, 0};
         exp_ns  = '{1, 0};
      end

      check_val("done_once", n_done, 1);
      check_val("beat_count", q_dir.size(), exp_dir.size());
      check_val("rule_violations", n_viol, 0);
      check_val("busy_after_done", ch_busy, 0);
      nb = (q_dir.size() < exp_dir.size()) ? q_dir.size() : exp_dir.size();
      seq_err = 0; ns_err = 0; dl_err = 0;
      for (int i = 0; i < nb; i++) begin
         if (q_dir[i] != exp_dir[i]) seq_err++;
         if (q_ns[i] != exp_ns[i]) ns_err++;
         if (q_dlen[i] != (((inj == 1 || inj == 3) && i == 1) ? 4 : 1)) dl_err++;
      end
      check_val("beat_direction_seq", seq_err, 0);
      check_val("nonseq_placement", ns_err, 0);
      if (rpct == 0) check_val("data_phase_len", dl_err, 0);

      if (inj == 3) begin
         check_val("abort_done_after_beat", done_cyc - prev_done_cyc, 1);
         check_val("abort_no_decrement", n_tsdec, 0);
      end else begin
         check_val("count_en_total", n_count, 2 * t);
         check_val("ts_decrements", n_tsdec, nbursts);
         check_val("s_en_total", n_sen, t + 1);
         check_val("d_en_total", n_den, t + 1);
         check_val("fifo_drained", fcnt, 0);
      end
      if (t == 0) begin
         check_val("zero_size_no_busreq", n_busreq, 0);
         check_val("zero_size_done_latency", done_cyc - en_cyc, 3);
      end
      if (t > 0 && spct == 0) check_val("start_to_first_addr", first_addr_cyc - en_cyc, 4);
      if (inj == 2 && q_gap.size() > 2) begin
         check_val("regrant_gap", q_gap[2], 3);
         check_val("normal_gap", q_gap[1], 2);
      end
   endtask

   // Test sequence.
   initial begin
      int hit;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset_outputs", out_vec(), 0);
      check_val("reset_busy", ch_busy, 0);
      @(posedge clk); #1 rst = 1'b0;

      run_xfer(8, 4, 0, 0, 0);  do_reset();
      run_xfer(6, 4, 0, 0, 0);  do_reset();
      run_xfer(0, 4, 0, 0, 0);  do_reset();
      run_xfer(8, 4, 0, 0, 1);  do_reset();
      run_xfer(8, 4, 0, 0, 2);  do_reset();
`ifdef DMAC_CH_ABORT_EN
      run_xfer(8, 4, 0, 0, 3);  do_reset();
`endif

      cfg_t = 8; cfg_b = 4;
      @(posedge clk); #1 ch_en = 1'b1;
      @(posedge clk); #1 ch_en = 1'b0;
      hit = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (trigger === 1'b1) begin
            hit = 1;
            break;
         end
      end
      check_val("reach_wr_data", hit, 1);
      rst = 1'b1;
      @(negedge clk);
      check_val("reset_mid_write", out_vec(), 0);
      @(posedge clk); #1 rst = 1'b0;

      for (int r = 0; r < 8; r++) begin
         int t, b;
         t = $urandom_range(0, 20);
         b = 1 << $urandom_range(0, 3);
         run_xfer(t, b, 30, 20, 0);
         do_reset();
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
